seven_segment_scan_driver: RTL and testbench
============================================

# seven_segment_scan_driver

Time-multiplexed scan driver for the 8-digit seven-segment display. Holds eight writable hex digits plus decimal points, steps the 3-bit digit select through 0..7 at a fixed refresh rate, and drives active-low anodes, segments and decimal point. It sits upstream of the anode selector: the `sel` it produces is the select that block decodes, and its `an` output is the same one-hot-low pattern.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit slot lasts. Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 4: leading cycles of each slot with all anodes off (anti-ghosting). Must be at least 1.

Ports:
- `clk` input, 1 bit: single clock.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `wr_en` input, 1 bit: digit write strobe.
- `wr_addr` input, 3 bits: digit index to write.
- `wr_data` input, 4 bits: hex value.
- `wr_dp` input, 1 bit: decimal point for that digit; 1 means lit.
- `digit_en` input, 8 bits: per-digit enable mask. A 0 blanks that digit.
- `sel` output, 3 bits: registered current digit index.
- `an` output, 8 bits: active-low anodes. Bit i corresponds to digit i.
- `seg` output, 7 bits: active-low segments, `seg[6:0]` = {CG,CF,CE,CD,CC,CB,CA}.
- `dp` output, 1 bit: active-low decimal point.

## Operation
- Digit file: 8 entries, each holding `val[3:0]` and `dp`. Reset clears all entries to 0.
  - When `wr_en` is sampled high, entry `wr_addr` loads {`wr_dp`, `wr_data`} at that edge.
  - Back-to-back writes are allowed, one per cycle. A later write to the same address overwrites the earlier one.
- Slot counter `cnt` runs 0..REFRESH_DIV-1 and wraps to 0.
  - Internal select `sel_i` increments modulo 8 on the edge where `cnt == REFRESH_DIV-1`, so 7 wraps to 0.
- Slot phase is derived from `cnt`:
  - BLANK when `cnt < BLANK_CYCLES`.
  - DRIVE otherwise.
  - Every slot passes BLANK → DRIVE → (next slot) BLANK.
- Output registers update every edge from the pre-edge internal state:
  - `sel` <= `sel_i`.
  - In BLANK, or when `digit_en[sel_i]` is 0: `an` <= 8'hFF, `seg` <= 7'h7F, `dp` <= 1.
  - In DRIVE with the digit enabled: `an` <= ~(8'b1 << `sel_i`), `seg` <= hex pattern of entry `sel_i`, `dp` <= ~entry.dp.
- Hex patterns, active-low {G..A}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset mid-scan: the next edge with `rst_n` low forces all state and outputs to reset values, regardless of `cnt`, `sel_i` or pending writes.
- `digit_en` changes take effect at the next edge. There is no effect on `cnt` or `sel_i`.

## Timing
- Reset values:
  - `cnt`=0, `sel_i`=0, digit file all 0.
  - `sel`=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- Edges are numbered 1,2,… from the first rising edge with `rst_n` high. Edge n samples `cnt` = (n-1) mod REFRESH_DIV.
- Output latency is one cycle behind the internal state.
- Write-to-display latency:
  - The write is sampled at edge k.
  - If digit `wr_addr` is in DRIVE at edge k+1, the new pattern is visible after edge k+1.
- A write in the same cycle as a slot change is still captured. It displays when that digit is next driven.
- Every digit is refreshed once per 8·REFRESH_DIV cycles.
- Each anode is low for exactly REFRESH_DIV−BLANK_CYCLES consecutive cycles per scan.
- Two anodes are never low in the same cycle.

## Structure
- Package `seven_seg_pkg` holds:
  - `typedef struct packed {logic dp; logic [3:0] val;} digit_t`.
  - The 16-entry active-low segment table as a localparam array.
  - Constants `NUM_DIGITS`=8 and `SEL_W`=3.
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit active-low lookup using the package table.
- The top level holds the counter, select, digit file and output registers.

## Test plan
All scenarios use REFRESH_DIV=10 and BLANK_CYCLES=2.
- **Reset, no writes, `digit_en`=FF:**
  - `an` stays FF through edge 2, reads FE from edge 3 to edge 10, then FF at edges 11–12, then FD at edge 13.
  - `seg`=40 whenever driven.
  - `sel` becomes 1 at edge 11.
- **Write digit 0=A with dp, before edge 3:** after edge 3, `seg`=08 and `dp`=0. Digit 1 (unwritten) later shows `seg`=40, `dp`=1.
- **Full wrap:** write digits i=i for i in 0..7 and run 80 cycles.
  - `sel` goes 0..7 and back to 0.
  - Each anode is low for 8 cycles; `an` is never two-hot.
  - `seg` sequence: 40,79,24,30,19,12,02,78.
- **`digit_en`=8'b1111_1101:** digit 1's slot keeps `an`=FF, `seg`=7F for all 10 cycles. The other digits are unaffected and slot timing is unchanged.
- **Write to the displayed digit mid-DRIVE:** write digit 0=F at edge 5. After edge 6, `seg`=0E while `an` stays FE.
- **Reset mid-scan:** assert `rst_n`=0 while `sel`=5 and `cnt`=7. After that edge, all outputs are at reset values and the digit file is cleared (shows 40 on the next drive), and the scan restarts with digit 0 at edge 3 after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low {G,F,E,D,C,B,A}.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;

    typedef struct packed {
        logic       dp;
        logic [3:0] val;
    } digit_t;

    typedef enum logic {
        PhBlank,
        PhDrive
    } phase_e;

    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-low seven-segment pattern lookup.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[val_i];

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with a writable digit file,
// a blanking window at the start of every slot, and registered active-low outputs.
module seven_segment_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]      scan_sel_q, scan_sel_d;
    digit_t                digits_q [NUM_DIGITS];
    digit_t                digits_d [NUM_DIGITS];
    phase_e                phase;
    logic                  slot_end;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    hex_to_seg u_hex_to_seg (
        .val_i (digits_q[scan_sel_q].val),
        .seg_o (cur_seg)
    );

    always_comb begin
        slot_end   = (cnt_q == CntW'(REFRESH_DIV - 1));
        phase      = (cnt_q < CntW'(BLANK_CYCLES)) ? PhBlank : PhDrive;
        cnt_d      = slot_end ? '0 : cnt_q + CntW'(1);
        scan_sel_d = slot_end ? scan_sel_q + SEL_W'(1) : scan_sel_q;
    end

    always_comb begin
        digits_d = digits_q;
        if (wr_en) begin
            digits_d[wr_addr] = '{dp: wr_dp, val: wr_data};
        end
    end

    // Outputs are computed from pre-edge state, so they trail the scan by one cycle.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (phase == PhDrive && digit_en[scan_sel_q]) begin
            an_d  = ~(NUM_DIGITS'(1) << scan_sel_q);
            seg_d = cur_seg;
            dp_d  = ~digits_q[scan_sel_q].dp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            scan_sel_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= '0;
            end
            sel        <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            scan_sel_q <= scan_sel_d;
            digits_q   <= digits_d;
            sel        <= scan_sel_q;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Self-checking bench for seven_segment_scan_driver with REFRESH_DIV=10, BLANK_CYCLES=2.
module tb_seven_segment_scan_driver;

    localparam int unsigned RD = 10;
    localparam int unsigned BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic [7:0] digit_en = 8'hFF;
    logic [2:0] sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] model_seg [8];
    logic       model_dp  [8];

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .digit_en (digit_en),
        .sel      (sel),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [3:0] wr_data;
        logic       wr_dp;
        logic [2:0] e_sel;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic r, logic we, logic [2:0] a, logic [3:0] d, logic wdp,
                                logic [2:0] s, logic [7:0] an_e, logic [6:0] seg_e,
                                logic dp_e);
        vec_t v;
        v.rst_n = r; v.wr_en = we; v.wr_addr = a; v.wr_data = d; v.wr_dp = wdp;
        v.e_sel = s; v.e_an = an_e; v.e_seg = seg_e; v.e_dp = dp_e;
        return v;
    endfunction

    function automatic vec_t idle(logic [2:0] s, logic [7:0] an_e, logic [6:0] seg_e,
                                  logic dp_e);
        return mk(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, s, an_e, seg_e, dp_e);
    endfunction

    function automatic vec_t rst_v();
        return mk(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 8'hFF, 7'h7F, 1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(string name, logic [2:0] s, logic [7:0] a, logic [6:0] g,
                           logic d);
        checks++;
        if ({sel, an, seg, dp} !== {s, a, g, d}) begin
            errors++;
            $display("FAIL %s: got sel=%0d an=%h seg=%h dp=%b, want sel=%0d an=%h seg=%h dp=%b",
                     name, sel, an, seg, dp, s, a, g, d);
        end
    endtask

    // Expected outputs after edge n of a run: slot and select from the edge index.
    task automatic check_model(string name, int n, logic [7:0] mask);
        int c;
        int s;
        logic [7:0] one;
        c = (n - 1) % RD;
        s = ((n - 1) / RD) % 8;
        one = 8'd1 << s;
        if (c < BC || !mask[s]) compare($sformatf("%s@%0d", name, n), 3'(s), 8'hFF, 7'h7F, 1'b1);
        else compare($sformatf("%s@%0d", name, n), 3'(s), ~one, model_seg[s], ~model_dp[s]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        repeat (2) step();
        compare("reset", 3'd0, 8'hFF, 7'h7F, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int low_cnt [8];
        int twohot;
        logic [7:0] nan;

        // Scenario: reset, no writes
        vecs.push_back(rst_v()); vecs.push_back(rst_v());
        for (int i = 0; i < 2; i++) vecs.push_back(idle(3'd0, 8'hFF, 7'h7F, 1'b1));
        for (int i = 0; i < 8; i++) vecs.push_back(idle(3'd0, 8'hFE, 7'h40, 1'b1));
        for (int i = 0; i < 2; i++) vecs.push_back(idle(3'd1, 8'hFF, 7'h7F, 1'b1));
        vecs.push_back(idle(3'd1, 8'hFD, 7'h40, 1'b1));
        // Scenario: digit 0 = A with dp written at edge 1
        vecs.push_back(rst_v()); vecs.push_back(rst_v());
        vecs.push_back(mk(1'b1, 1'b1, 3'd0, 4'hA, 1'b1, 3'd0, 8'hFF, 7'h7F, 1'b1));
        vecs.push_back(idle(3'd0, 8'hFF, 7'h7F, 1'b1));
        for (int i = 0; i < 8; i++) vecs.push_back(idle(3'd0, 8'hFE, 7'h08, 1'b0));
        for (int i = 0; i < 2; i++) vecs.push_back(idle(3'd1, 8'hFF, 7'h7F, 1'b1));
        vecs.push_back(idle(3'd1, 8'hFD, 7'h40, 1'b1));
        // Scenario: write displayed digit mid-DRIVE at edge 5
        vecs.push_back(rst_v()); vecs.push_back(rst_v());
        for (int i = 0; i < 2; i++) vecs.push_back(idle(3'd0, 8'hFF, 7'h7F, 1'b1));
        for (int i = 0; i < 2; i++) vecs.push_back(idle(3'd0, 8'hFE, 7'h40, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd0, 4'hF, 1'b0, 3'd0, 8'hFE, 7'h40, 1'b1));
        for (int i = 0; i < 2; i++) vecs.push_back(idle(3'd0, 8'hFE, 7'h0E, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            wr_dp   = vecs[i].wr_dp;
            step();
            compare($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_an, vecs[i].e_seg,
                    vecs[i].e_dp);
        end
        wr_en = 1'b0;

        // Full wrap: digit i = i, written back-to-back on edges 1..8
        model_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        for (int i = 0; i < 8; i++) begin
            model_dp[i] = 1'b0;
            low_cnt[i] = 0;
        end
        twohot = 0;
        do_reset();
        for (int n = 1; n <= 81; n++) begin
            wr_en   = (n <= 8);
            wr_addr = 3'(n - 1);
            wr_data = 4'(n - 1);
            wr_dp   = 1'b0;
            step();
            check_model("wrap", n, 8'hFF);
            nan = ~an;
            for (int i = 0; i < 8; i++) if (!an[i]) low_cnt[i]++;
            if ($countones(nan) > 1) twohot++;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (low_cnt[i] != 8) begin
                errors++;
                $display("FAIL anode_low[%0d]: got %0d cycles, want 8", i, low_cnt[i]);
            end
        end
        checks++;
        if (twohot != 0) begin
            errors++;
            $display("FAIL onehot: got %0d two-hot cycles, want 0", twohot);
        end

        // digit_en masks digit 1
        for (int i = 0; i < 8; i++) begin
            model_seg[i] = 7'h40;
            model_dp[i]  = 1'b0;
        end
        do_reset();
        digit_en = 8'b1111_1101;
        for (int n = 1; n <= 30; n++) begin
            step();
            check_model("mask", n, 8'b1111_1101);
        end
        digit_en = 8'hFF;

        // Reset mid-scan at sel=5, cnt=7 clears the digit file
        model_seg[0] = 7'h00;
        model_dp[0]  = 1'b1;
        do_reset();
        for (int n = 1; n <= 57; n++) begin
            wr_en   = (n == 1);
            wr_addr = 3'd0;
            wr_data = 4'h8;
            wr_dp   = 1'b1;
            step();
            check_model("prerst", n, 8'hFF);
        end
        wr_en = 1'b0;
        rst_n = 1'b0;
        step();
        compare("mid_reset", 3'd0, 8'hFF, 7'h7F, 1'b1);
        rst_n = 1'b1;
        step();
        compare("post_rst_e1", 3'd0, 8'hFF, 7'h7F, 1'b1);
        step();
        compare("post_rst_e2", 3'd0, 8'hFF, 7'h7F, 1'b1);
        step();
        compare("post_rst_e3", 3'd0, 8'hFE, 7'h40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
